// File: rtl/frog_game_ctrl.sv
// Frog game controller: owns the frog position, detects collisions against
// every lane's car, tracks lives and produces the level that scales car speed.
module frog_game_ctrl #(
    parameter int NUM_LANES      = 4,
    parameter int FIRST_LANE_ROW = 2,
    parameter int GRID_W         = 20,
    parameter int GRID_H         = 15,
    parameter int START_X        = 10,
    parameter int START_Y        = 14,
    parameter int CAR_LEN        = 2,
    parameter int LIVES          = 3,
    parameter int MAX_LEVEL      = 31,
    parameter int HIT_CYCLES     = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_up,
    input  logic                   i_down,
    input  logic                   i_left,
    input  logic                   i_right,
    input  logic                   i_start,
    input  logic [5*NUM_LANES-1:0] i_car_x,
    output logic [4:0]             o_frog_x,
    output logic [3:0]             o_frog_y,
    output logic [4:0]             o_level,
    output logic [1:0]             o_lives,
    output logic [1:0]             o_state,
    output logic                   o_hit,
    output logic                   o_win
);

    localparam int CNT_W = (HIT_CYCLES > 1) ? $clog2(HIT_CYCLES) : 1;

    localparam logic [4:0]       START_X_L   = 5'(START_X);
    localparam logic [3:0]       START_Y_L   = 4'(START_Y);
    localparam logic [1:0]       LIVES_L     = 2'(LIVES);
    localparam logic [4:0]       MAX_LEVEL_L = 5'(MAX_LEVEL);
    localparam logic [4:0]       X_MAX       = 5'(GRID_W - 1);
    localparam logic [3:0]       Y_MAX       = 4'(GRID_H - 1);
    localparam logic [CNT_W-1:0] HIT_LAST    = CNT_W'(HIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_HIT       = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hit_cnt;
    logic             collide;

    // The state register is itself the registered state output
    assign o_state = state;

    // Collision: frog row matches a lane and frog column lies within that car (wrapping)
    always_comb begin
        collide = 1'b0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            for (int unsigned j = 0; j < CAR_LEN; j++) begin
                if ((int'(o_frog_y) == FIRST_LANE_ROW + int'(k)) &&
                    (int'(o_frog_x) == (int'(i_car_x[5*k +: 5]) + int'(j)) % GRID_W)) begin
                    collide = 1'b1;
                end
            end
        end
    end

    // Game FSM with registered frog position, level, lives and event pulses
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state    <= ST_PLAY;
            o_frog_x <= START_X_L;
            o_frog_y <= START_Y_L;
            o_level  <= 5'd1;
            o_lives  <= LIVES_L;
            o_hit    <= 1'b0;
            o_win    <= 1'b0;
            hit_cnt  <= '0;
        end else begin
            o_hit <= 1'b0;
            o_win <= 1'b0;
            case (state)
                ST_PLAY: begin
                    if (collide) begin
                        state   <= ST_HIT;
                        o_lives <= o_lives - 2'd1;
                        o_hit   <= 1'b1;
                        hit_cnt <= HIT_LAST;
                    end else if (o_frog_y == '0) begin
                        if (o_level < MAX_LEVEL_L) begin
                            o_level <= o_level + 5'd1;
                        end
                        o_frog_x <= START_X_L;
                        o_frog_y <= START_Y_L;
                        o_win    <= 1'b1;
                    end else if (i_up) begin
                        if (o_frog_y != '0) begin
                            o_frog_y <= o_frog_y - 4'd1;
                        end
                    end else if (i_down) begin
                        if (o_frog_y < Y_MAX) begin
                            o_frog_y <= o_frog_y + 4'd1;
                        end
                    end else if (i_left) begin
                        if (o_frog_x != '0) begin
                            o_frog_x <= o_frog_x - 5'd1;
                        end
                    end else if (i_right) begin
                        if (o_frog_x < X_MAX) begin
                            o_frog_x <= o_frog_x + 5'd1;
                        end
                    end
                end
                ST_HIT: begin
                    if (hit_cnt == '0) begin
                        if (o_lives == '0) begin
                            state <= ST_GAME_OVER;
                        end else begin
                            state    <= ST_PLAY;
                            o_frog_x <= START_X_L;
                            o_frog_y <= START_Y_L;
                        end
                    end else begin
                        hit_cnt <= hit_cnt - CNT_W'(1);
                    end
                end
                ST_GAME_OVER: begin
                    if (i_start) begin
                        state    <= ST_PLAY;
                        o_lives  <= LIVES_L;
                        o_level  <= 5'd1;
                        o_frog_x <= START_X_L;
                        o_frog_y <= START_Y_L;
                    end
                end
                default: begin
                    state <= ST_PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Scoreboard bench for frog_game_ctrl: stimulus pushes hand-computed expected
// outputs per cycle, a monitor pops and compares them after each clock edge.
module tb_frog_game_ctrl;

    logic        clk;
    logic        i_Rst_n;
    logic        i_up, i_down, i_left, i_right, i_start;
    logic [19:0] i_car_x;
    logic [4:0]  o_frog_x;
    logic [3:0]  o_frog_y;
    logic [4:0]  o_level;
    logic [1:0]  o_lives;
    logic [1:0]  o_state;
    logic        o_hit;
    logic        o_win;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string      name;
        logic [4:0] fx;
        logic [3:0] fy;
        logic [4:0] lvl;
        logic [1:0] lv;
        logic [1:0] st;
        logic       hit;
        logic       win;
    } exp_t;

    exp_t exp_q[$];

    // Hand-tracked expected values, updated explicitly by the stimulus
    logic [4:0] ex_fx;
    logic [3:0] ex_fy;
    logic [4:0] ex_lvl;
    logic [1:0] ex_lv;
    logic [1:0] ex_st;

    frog_game_ctrl #(
        .NUM_LANES(4), .FIRST_LANE_ROW(2), .GRID_W(20), .GRID_H(15),
        .START_X(10), .START_Y(14), .CAR_LEN(2), .LIVES(3),
        .MAX_LEVEL(31), .HIT_CYCLES(8)
    ) dut (
        .i_Clk(clk), .i_Rst_n(i_Rst_n),
        .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
        .i_start(i_start), .i_car_x(i_car_x),
        .o_frog_x(o_frog_x), .o_frog_y(o_frog_y), .o_level(o_level),
        .o_lives(o_lives), .o_state(o_state), .o_hit(o_hit), .o_win(o_win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle, compared 1 time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if ({o_frog_x, o_frog_y, o_level, o_lives, o_state, o_hit, o_win} !==
                    {e.fx, e.fy, e.lvl, e.lv, e.st, e.hit, e.win}) begin
                    tests_failed++;
                    $display("FAIL %s: got x=%0d y=%0d lvl=%0d lives=%0d st=%0d hit=%b win=%b, want x=%0d y=%0d lvl=%0d lives=%0d st=%0d hit=%b win=%b",
                             e.name, o_frog_x, o_frog_y, o_level, o_lives, o_state, o_hit, o_win,
                             e.fx, e.fy, e.lvl, e.lv, e.st, e.hit, e.win);
                end
            end
        end
    end

    // Drive one cycle of inputs and push the outputs expected after the next edge
    task automatic step(input string nm, input logic rst_n, input logic u, input logic d,
                        input logic l, input logic r, input logic s,
                        input logic h, input logic w);
        exp_t e;
        @(negedge clk);
        i_Rst_n = rst_n;
        i_up = u; i_down = d; i_left = l; i_right = r; i_start = s;
        e.name = nm;
        e.fx = ex_fx; e.fy = ex_fy; e.lvl = ex_lvl; e.lv = ex_lv; e.st = ex_st;
        e.hit = h; e.win = w;
        exp_q.push_back(e);
    endtask

    task automatic set_start_pos();
        ex_fx = 5'd10;
        ex_fy = 4'd14;
    endtask

    task automatic up_n(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            ex_fy = ex_fy - 4'd1;
            step(nm, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic left_n(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            ex_fx = ex_fx - 5'd1;
            step(nm, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Collision evaluated on the idle step after reaching the lane; holds the
    // frog for 8 HIT cycles while move/start pulses are offered and ignored
    task automatic hit_seq(input logic [1:0] lv_after, input logic to_game_over);
        ex_lv = lv_after;
        ex_st = 2'd1;
        step("hit_pulse", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step("hit_hold", 1'b1, i[0], 1'b0, 1'b0, ~i[0], 1'b1, 1'b0, 1'b0);
        end
        if (to_game_over) begin
            ex_st = 2'd2;
        end else begin
            ex_st = 2'd0;
            set_start_pos();
        end
        step("hit_exit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic goal_trip(input logic [4:0] lvl_after);
        up_n(14, "walk_goal");
        ex_lvl = lvl_after;
        set_start_pos();
        step("win", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        i_Rst_n = 1'b0;
        i_up = 1'b0; i_down = 1'b0; i_left = 1'b0; i_right = 1'b0; i_start = 1'b0;
        // lane0 = 18 (cells 18,19), lanes 1..3 = 10 (cells 10,11)
        i_car_x = {5'd10, 5'd10, 5'd10, 5'd18};
        set_start_pos();
        ex_lvl = 5'd1; ex_lv = 2'd3; ex_st = 2'd0;

        // Reset and first move
        step("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("reset1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("idle",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        up_n(1, "up_first");
        ex_fy = 4'd14;
        step("down", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clamping and move priority at the left/bottom corner
        left_n(10, "walk_left");
        step("left_down_clamp", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_fy = 4'd13;
        step("up_beats_right", 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Lane0 car at 18 does not cover x=0
        up_n(11, "walk_lane");
        step("no_hit_18a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("no_hit_18b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        up_n(2, "walk_goal0");
        ex_lvl = 5'd2;
        set_start_pos();
        step("win_lvl2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Lane0 car at 19 wraps onto x=0: three hits end the game
        i_car_x = {5'd10, 5'd10, 5'd10, 5'd19};
        left_n(10, "walk_left");
        up_n(12, "walk_lane");
        hit_seq(2'd2, 1'b0);
        left_n(10, "walk_left");
        up_n(12, "walk_lane");
        hit_seq(2'd1, 1'b0);
        left_n(10, "walk_left");
        up_n(12, "walk_lane");
        hit_seq(2'd0, 1'b1);
        step("go_ignore_up",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("go_ignore_left", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_st = 2'd0; ex_lv = 2'd3; ex_lvl = 5'd1;
        set_start_pos();
        step("restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("start_in_play", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Level climb to saturation with cars parked away from column 10
        i_car_x = '0;
        for (int lvl = 2; lvl <= 31; lvl++) begin
            goal_trip(5'(lvl));
        end
        goal_trip(5'd31);

        // Reset in the middle of a HIT window with one life left
        i_car_x = {5'd10, 5'd10, 5'd10, 5'd19};
        left_n(10, "walk_left");
        up_n(12, "walk_lane");
        hit_seq(2'd2, 1'b0);
        left_n(10, "walk_left");
        up_n(12, "walk_lane");
        ex_lv = 2'd1; ex_st = 2'd1;
        step("hit_pulse2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hit_hold2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        ex_st = 2'd0; ex_lv = 2'd3; ex_lvl = 5'd1;
        set_start_pos();
        step("reset_mid_hit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("after_reset",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
